// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM device-side responder: command codes,
// mode-register field positions, error flag indices and burst helpers.
package sdram_pkg;

  // {cs, ras, cas, we}
  localparam logic [3:0] CMD_MRS = 4'b0000;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  localparam int A10_BIT = 10;
  localparam int BL_LSB  = 0;
  localparam int CL_LSB  = 4;

  localparam int COL_W = 9;
  localparam int ROW_W = 13;
  localparam int PAGE  = 512;
  localparam int BLW   = COL_W + 1;

  localparam logic [2:0] BL_FULL = 3'b111;
  localparam logic [2:0] CL_2    = 3'd2;

  localparam int ERR_EARLY  = 0;
  localparam int ERR_CLOSED = 1;
  localparam int ERR_OPEN   = 2;
  localparam int ERR_TRCD   = 3;

  typedef enum logic [2:0] {
    ST_PWR,
    ST_PRE,
    ST_REF,
    ST_MRS_WAIT,
    ST_READY
  } init_st_e;

  typedef struct packed {
    logic             wr;
    logic [1:0]       bank;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } beat_t;

  // Unlisted BL codes fall back to a single beat.
  function automatic logic [BLW-1:0] bl_beats(input logic [2:0] code);
    case (code)
      3'b000:  return BLW'(1);
      3'b001:  return BLW'(2);
      3'b010:  return BLW'(4);
      3'b011:  return BLW'(8);
      BL_FULL: return BLW'(PAGE);
      default: return BLW'(1);
    endcase
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Backing store: 2^AW x 16 RAM, per-byte write enable, one write and one
// read port with a registered read (read-before-write on a shared address).
module sdram_resp_mem #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic [1:0]    wen,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [7:0] ram [2**AW];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (wen[l]) ram[waddr] <= wdata[8*l +: 8];
      rd_q <= ram[raddr];
    end

    assign rdata[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/sdram_resp.sv
// SDR SDRAM device emulator: decodes controller commands, tracks init, mode
// register and open rows, and serves bursts from on-chip memory.
module sdram_resp
  import sdram_pkg::*;
#(
  parameter int MEM_AW   = 12,
  parameter int INIT_CYC = 20000,
  parameter int TRCD     = 2,      // must be >= 1
  parameter int REF_MIN  = 2       // must be >= 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cke,
  input  logic        cs,
  input  logic        ras,
  input  logic        cas,
  input  logic        we,
  input  logic [1:0]  dqm,
  input  logic [12:0] sd_addr,
  input  logic [1:0]  sd_bank,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_out_en,
  output logic        init_done,
  output logic [3:0]  err,
  output logic [15:0] ref_cnt
);

  localparam int IW     = $clog2(INIT_CYC + 1);
  localparam int RW     = $clog2(REF_MIN + 1);
  localparam int DW     = $clog2(TRCD + 1);
  localparam int STAGES = 1;

  // ---------------- command decode ----------------
  logic [3:0] cmd;
  logic       is_act;
  logic       is_rd;
  logic       is_wr;
  logic       is_pre;
  logic       is_ref;
  logic       is_mrs;
  logic       rw;
  logic       all_bank;

  assign cmd      = (cke && !cs) ? {cs, ras, cas, we} : CMD_NOP;
  assign is_act   = (cmd == CMD_ACT);
  assign is_rd    = (cmd == CMD_RD);
  assign is_wr    = (cmd == CMD_WR);
  assign is_pre   = (cmd == CMD_PRE);
  assign is_ref   = (cmd == CMD_REF);
  assign is_mrs   = (cmd == CMD_MRS);
  assign rw       = is_rd || is_wr;
  assign all_bank = sd_addr[A10_BIT];

  // ---------------- init FSM and mode register ----------------
  init_st_e      st;
  logic [IW-1:0] pwr_cnt;
  logic [RW-1:0] init_ref;
  logic [2:0]    mode_bl;
  logic          cl3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= ST_PWR;
      pwr_cnt   <= '0;
      init_ref  <= '0;
      init_done <= 1'b0;
      mode_bl   <= '0;
      cl3       <= 1'b0;
    end else begin
      case (st)
        ST_PWR: begin
          if (cke && pwr_cnt != IW'(INIT_CYC)) pwr_cnt <= pwr_cnt + IW'(1);
          if (is_pre && all_bank && pwr_cnt == IW'(INIT_CYC)) st <= ST_PRE;
        end
        ST_PRE, ST_REF: begin
          if (is_ref) begin
            init_ref <= init_ref + RW'(1);
            st       <= (init_ref >= RW'(REF_MIN - 1)) ? ST_MRS_WAIT : ST_REF;
          end
        end
        ST_MRS_WAIT, ST_READY: begin
          // MRS is also honoured after init so the mode can be reprogrammed.
          if (is_mrs) begin
            mode_bl   <= sd_addr[BL_LSB +: 3];
            cl3       <= (sd_addr[CL_LSB +: 3] != CL_2);
            st        <= ST_READY;
            init_done <= 1'b1;
          end
        end
        default: st <= ST_PWR;
      endcase
    end
  end

  // ---------------- bank state, errors, refresh count ----------------
  logic [3:0]            open_b;
  logic [3:0][ROW_W-1:0] row_r;
  logic [3:0][DW-1:0]    rcd;
  logic [3:0]            err_set;
  logic                  rw_ok;

  assign rw_ok = rw && open_b[sd_bank];

  always_comb begin
    err_set = '0;
    if ((is_act || rw) && !init_done)            err_set[ERR_EARLY]  = 1'b1;
    if (rw && !open_b[sd_bank])                  err_set[ERR_CLOSED] = 1'b1;
    if (is_act && open_b[sd_bank])               err_set[ERR_OPEN]   = 1'b1;
    if (is_ref && (|open_b))                     err_set[ERR_OPEN]   = 1'b1;
    if (rw_ok && rcd[sd_bank] != '0)             err_set[ERR_TRCD]   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_b  <= '0;
      row_r   <= '0;
      rcd     <= '0;
      err     <= '0;
      ref_cnt <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (rcd[b] != '0) rcd[b] <= rcd[b] - DW'(1);
      if (is_act) begin
        open_b[sd_bank] <= 1'b1;
        row_r[sd_bank]  <= sd_addr;
        rcd[sd_bank]    <= DW'(TRCD - 1);
      end
      if (is_pre) begin
        if (all_bank) open_b <= '0;
        else          open_b[sd_bank] <= 1'b0;
      end
      err <= err | err_set;
      if (is_ref && ref_cnt != 16'hFFFF) ref_cnt <= ref_cnt + 16'd1;
    end
  end

  // ---------------- burst engine ----------------
  beat_t            bst;
  logic             bst_act;
  logic             bst_full;
  logic [COL_W-1:0] bst_left;
  beat_t            beat;
  logic             beat_v;
  logic             pre_stop;
  logic [BLW-1:0]   bl_len;
  logic             bl_full;

  assign pre_stop = is_pre && (all_bank || sd_bank == bst.bank);
  assign bl_len   = bl_beats(mode_bl);
  assign bl_full  = (mode_bl == BL_FULL);

  // A fresh READ/WRITE owns this cycle's beat; otherwise the running burst
  // continues unless a precharge to its bank cuts it off.
  always_comb begin
    beat   = bst;
    beat_v = 1'b0;
    if (rw_ok) begin
      beat_v    = 1'b1;
      beat.wr   = is_wr;
      beat.bank = sd_bank;
      beat.row  = row_r[sd_bank];
      beat.col  = sd_addr[COL_W-1:0];
    end else if (bst_act && !pre_stop) begin
      beat_v = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bst      <= '0;
      bst_act  <= 1'b0;
      bst_full <= 1'b0;
      bst_left <= '0;
    end else if (rw_ok) begin
      bst      <= beat;
      bst.col  <= beat.col + COL_W'(1);
      bst_act  <= bl_full || (bl_len != BLW'(1));
      bst_full <= bl_full;
      bst_left <= COL_W'(bl_len - BLW'(1));
    end else if (bst_act) begin
      if (pre_stop) begin
        bst_act <= 1'b0;
      end else begin
        bst.col <= bst.col + COL_W'(1);
        if (!bst_full) begin
          bst_left <= bst_left - COL_W'(1);
          if (bst_left == COL_W'(1)) bst_act <= 1'b0;
        end
      end
    end
  end

  // ---------------- memory ----------------
  logic [MEM_AW-1:0] mem_addr;
  logic [1:0]        mem_wen;
  logic [15:0]       rd_data;
  logic              rd_issue;

  assign mem_addr = MEM_AW'({beat.bank, beat.row, beat.col});
  assign mem_wen  = (beat_v && beat.wr) ? ~dqm : 2'b00;
  assign rd_issue = beat_v && !beat.wr;

  sdram_resp_mem #(.AW(MEM_AW)) u_mem (
    .clk   (clk),
    .wen   (mem_wen),
    .waddr (mem_addr),
    .wdata (dq_in),
    .raddr (mem_addr),
    .rdata (rd_data)
  );

  // ---------------- read return pipeline ----------------
  // vld_pipe[0] is aligned with rd_data; CL=3 takes one extra stage.
  logic [STAGES:0] vld_pipe;
  logic [15:0]     dat_pipe;
  logic            out_v;

  assign out_v = cl3 ? vld_pipe[STAGES] : vld_pipe[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      dat_pipe  <= '0;
      dq_out    <= '0;
      dq_out_en <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], rd_issue};
      dat_pipe  <= rd_data;
      dq_out_en <= out_v;
      if (out_v) dq_out <= cl3 ? dat_pipe : rd_data;
    end
  end

endmodule

// File: doc/sdram_resp.md
Name: sdram_resp

Overview:
- Synthesizable SDRAM device-side responder. It decodes the command bus driven by the team's SDRAM controller and emulates a 4-bank x16 SDR SDRAM.
- It tracks initialization, the mode register and open rows, and it serves write and read bursts from a small on-chip memory.
- Used in FPGA loopback and simulation benches in place of the external chip, together with a protocol-error monitor.

Parameters:
MEM_AW, 12, stored-word address width; word index = low MEM_AW bits of {bank[1:0], row[12:0], col[8:0]}
INIT_CYC, 20000, minimum cycles with cke high before the first PRECHARGE is accepted as part of init
TRCD, 2, minimum cycles from ACTIVE to READ/WRITE on the same bank
REF_MIN, 2, AUTO REFRESH commands required before MRS during init

Ports:
clk  in  1  device clock (command/data sampled on posedge)
rst_n  in  1  asynchronous active-low reset
cke  in  1  clock enable; commands ignored while 0
cs  in  1  chip select, active low
ras  in  1  row strobe
cas  in  1  column strobe
we  in  1  write enable
dqm  in  2  byte mask; bit1 masks [15:8], bit0 masks [7:0]
sd_addr  in  13  row / column / mode / A10 field
sd_bank  in  2  bank select
dq_in  in  16  write data from controller
dq_out  out  16  read data
dq_out_en  out  1  read data valid / drive enable
init_done  out  1  init sequence complete
err  out  4  sticky protocol-error flags
ref_cnt  out  16  saturating count of AUTO REFRESH commands

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: dq_out=0, dq_out_en=0, init_done=0, err=0, ref_cnt=0. All banks closed; mode register = 0 (CL=2, BL=1). Memory contents are not cleared.
- Command decode on {cs,ras,cas,we} when cke=1: 0111 NOP, 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 AUTO REFRESH, 0000 MRS. cs=1 is treated as NOP.
- Init FSM:
  - PWR: count cke-high cycles up to INIT_CYC.
  - PWR -> PRE on PRECHARGE with A10=1 once the count has been reached.
  - PRE -> REF on AUTO REFRESH; REF counts refreshes.
  - REF -> MRS_WAIT after REF_MIN refreshes; an MRS there latches the mode register and moves to READY.
  - init_done=1 from the cycle after MRS.
  - An early PRECHARGE in PWR is ignored.
- Mode register: BL = sd_addr[2:0]; 000/001/010/011 = 1/2/4/8 beats, 111 = full page (512). CL = sd_addr[6:4]; only 2 or 3 are legal, any other value is treated as 3.
- ACTIVE: sets open[bank]=1, row[bank]=sd_addr, and starts the tRCD counter for that bank.
- PRECHARGE: A10=1 closes all banks; otherwise it closes sd_bank.
- WRITE at cycle T, column c = sd_addr[8:0]:
  - Beats at T, T+1, ... write dq_in to column (c+i) mod 512 of the open row.
  - Byte lanes whose dqm bit is 1 are not written.
  - Burst ends after BL beats.
- READ at cycle T:
  - Address beat i is issued at T+i through a 1-cycle registered memory read.
  - Data is delayed so beat i appears on dq_out with dq_out_en=1 at cycle T+CL+i.
  - Column wrap is mod 512.
- Burst termination:
  - A new READ/WRITE interrupts the current burst; the new command's beat 0 wins that cycle.
  - A PRECHARGE to the burst's bank stops issuing at that cycle. A write beat on the precharge cycle is not stored. Read beats already issued still emerge, so the last output is at P+CL-1.
  - Full-page bursts run until they are terminated.
- dq_out_en=0 whenever no read beat is due. dq_out holds its last value when idle.
- err bits are sticky until reset:
  - [0] ACTIVE/READ/WRITE before init_done.
  - [1] READ/WRITE to a closed bank; the command is ignored.
  - [2] ACTIVE to an already-open bank; the row is still replaced.
  - [3] READ/WRITE fewer than TRCD cycles after ACTIVE on that bank; the command is still executed.
- AUTO REFRESH with any bank open sets err[2]; ref_cnt still increments, saturating at 0xFFFF.
- Reset mid-burst: all outputs return to their reset values on the next edge of rst_n low; the read pipeline is flushed.

Decomposition:
- Shared package sdram_pkg holds:
  - the command encodings (NOP/ACT/RD/WR/PRE/REF/MRS)
  - the A10 all-bank bit position
  - mode field positions: BL [2:0], CL [6:4]
  - page size 512
  - err bit indices
- Sub-module sdram_resp_mem: 2^MEM_AW x 16 RAM with 2-bit byte-write enable, one write port and one read port, 1-cycle registered read.

Test Plan:
- Init and MRS: reset, cke=1 for 20000 cycles, PRE with A10=1, 2x REF, MRS sd_addr=0x027 -> init_done=1 the cycle after MRS, ref_cnt=2, err=0; CL=2, full page.
- Write burst terminated by PRECHARGE: ACT bank1 row 0x0005, wait 2, WRITE col 0 with data 0x1000+i for 8 cycles, PRE on the 9th -> cols 0..7 = 0x1000..0x1007; col 8 unchanged.
- Read burst terminated by PRECHARGE: ACT bank1 row 5, READ col 0 at T, PRE at T+8 -> dq_out_en=1 for T+2..T+9 with 0x1000..0x1007, low at T+10.
- Byte mask and wrap: WRITE 0xABCD over 0x1234 with dqm=2'b10, then read -> 0x12CD. WRITE at col 510, 4 beats -> cols 510, 511, 0, 1 written.
- Error flags: READ to a closed bank -> err[1]=1 and no dq_out_en. ACT to an open bank -> err[2]. READ 1 cycle after ACT -> err[3] set and data still returned.
- Reset mid-read: assert rst_n=0 during a full-page read -> dq_out_en=0 and init_done=0 immediately; after release, no residual beats.
